mux2x1_out_buffer: RTL and testbench

Downstream capture stage for the 2x1 mux: samples each valid mux result (data plus the select that produced it) into a small synchronous FIFO. It presents the entries to a consumer through a valid/ready handshake. It also keeps saturating statistics: results dropped because the FIFO was full, and results that came from input i1. It lets the TB environment and downstream logic consume mux results at their own rate without losing ordering.

---
 rtl/mux2x1_out_buffer_if.sv | 24 ++
 rtl/mux2x1_out_buffer.sv | 84 ++++++++
 tb/tb_mux2x1_out_buffer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mux2x1_out_buffer_if.sv
// Valid/ready capture and consume channels of the mux output buffer.
// The buffer sits on the slave side. The producer and consumer environment sits on the master side.
interface mux2x1_out_buffer_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_sel;
    logic             out_ready;

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/mux2x1_out_buffer.sv
// Capture FIFO for 2x1 mux results, storing {sel,data} pairs.
// It also keeps saturating drop and sel1 statistics.
module mux2x1_out_buffer #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int CNTW  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    mux2x1_out_buffer_if.slave       bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [CNTW-1:0]          drop_cnt,
    output logic [CNTW-1:0]          sel1_cnt
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH:0]  mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q,  count_d;
    logic [CNTW-1:0] drop_q,   drop_d;
    logic [CNTW-1:0] sel1_q,   sel1_d;
    logic            full_w, empty_w, push, pop;

    assign full_w  = (count_q == (AW+1)'(DEPTH));
    assign empty_w = (count_q == '0);
    // Handshake status is decoded from registered count only.
    assign push    = bus.in_valid & ~full_w;
    assign pop     = bus.out_ready & ~empty_w;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        sel1_d   = sel1_q;
        if (push)
            wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)
            rd_ptr_d = rd_ptr_q + AW'(1);
        if (push && !pop)
            count_d = count_q + (AW+1)'(1);
        else if (pop && !push)
            count_d = count_q - (AW+1)'(1);
        if (bus.in_valid && full_w && !(&drop_q))
            drop_d = drop_q + CNTW'(1);
        if (push && bus.in_sel && !(&sel1_q))
            sel1_d = sel1_q + CNTW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            sel1_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            sel1_q   <= sel1_d;
        end
    end

    // Storage is intentionally not reset; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {bus.in_sel, bus.in_data};
    end

    assign bus.in_ready  = ~full_w;
    assign bus.out_valid = ~empty_w;
    assign bus.out_data  = mem_q[rd_ptr_q][WIDTH-1:0];
    assign bus.out_sel   = mem_q[rd_ptr_q][WIDTH];
    assign count         = count_q;
    assign full          = full_w;
    assign empty         = empty_w;
    assign drop_cnt      = drop_q;
    assign sel1_cnt      = sel1_q;
endmodule

// File: tb/tb_mux2x1_out_buffer.sv
// Randomized and directed bench for mux2x1_out_buffer against a queue-based reference model.
// A second instance with 3-bit counters receives the same stimulus so that saturation can be observed.
module tb_mux2x1_out_buffer;
    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    mux2x1_out_buffer_if #(.WIDTH(WIDTH)) bus_m ();
    mux2x1_out_buffer_if #(.WIDTH(WIDTH)) bus_s ();

    logic [2:0] count_m, count_s;
    logic       full_m, full_s, empty_m, empty_s;
    logic [7:0] drop_m, sel1_m;
    logic [2:0] drop_s, sel1_s;

    mux2x1_out_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(8)) dut_m (
        .clk(clk), .rst(rst), .bus(bus_m),
        .count(count_m), .full(full_m), .empty(empty_m),
        .drop_cnt(drop_m), .sel1_cnt(sel1_m)
    );

    mux2x1_out_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNTW(3)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s),
        .count(count_s), .full(full_s), .empty(empty_s),
        .drop_cnt(drop_s), .sel1_cnt(sel1_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: an ordered list of {sel,data} plus unbounded event totals.
    logic [WIDTH:0] ref_q[$];
    int             ref_drop = 0;
    int             ref_sel1 = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int max);
        return (v > max) ? max : v;
    endfunction

    task automatic check_all();
        int n = ref_q.size();
        check_val("count",     32'(count_m),          32'(n));
        check_val("full",      32'(full_m),           32'(n == DEPTH));
        check_val("empty",     32'(empty_m),          32'(n == 0));
        check_val("in_ready",  32'(bus_m.in_ready),   32'(n != DEPTH));
        check_val("out_valid", 32'(bus_m.out_valid),  32'(n != 0));
        if (n != 0) begin
            check_val("out_data", 32'(bus_m.out_data), 32'(ref_q[0][WIDTH-1:0]));
            check_val("out_sel",  32'(bus_m.out_sel),  32'(ref_q[0][WIDTH]));
        end
        check_val("drop_cnt",   32'(drop_m), 32'(sat(ref_drop, 255)));
        check_val("sel1_cnt",   32'(sel1_m), 32'(sat(ref_sel1, 255)));
        check_val("count_s",    32'(count_s), 32'(n));
        check_val("drop_cnt_s", 32'(drop_s), 32'(sat(ref_drop, 7)));
        check_val("sel1_cnt_s", 32'(sel1_s), 32'(sat(ref_sel1, 7)));
    endtask

    // Drives one cycle of stimulus, advances the model at the edge, and checks #1 later.
    task automatic step(input logic v, input logic [WIDTH-1:0] d, input logic s, input logic r);
        bit do_push, do_pop;
        bus_m.in_valid = v; bus_m.in_data = d; bus_m.in_sel = s; bus_m.out_ready = r;
        bus_s.in_valid = v; bus_s.in_data = d; bus_s.in_sel = s; bus_s.out_ready = r;
        @(posedge clk);
        do_push = v && (ref_q.size() < DEPTH);
        do_pop  = r && (ref_q.size() > 0);
        if (v && ref_q.size() == DEPTH) ref_drop++;
        if (do_push && s) ref_sel1++;
        if (do_pop) void'(ref_q.pop_front());
        if (do_push) ref_q.push_back({s, d});
        #1;
        check_all();
    endtask

    task automatic apply_reset_midcycle();
        #2;
        rst = 1'b1;
        #1;
        ref_q.delete();
        ref_drop = 0;
        ref_sel1 = 0;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    int sel1_before;

    initial begin
        rst = 1'b1;
        step_idle_inputs();
        #3;
        check_all();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single pass
        step(1'b1, 4'hA, 1'b1, 1'b0);
        check_val("sp_data", 32'(bus_m.out_data), 32'hA);
        check_val("sp_sel",  32'(bus_m.out_sel), 32'h1);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        check_val("sp_empty", 32'(empty_m), 32'h1);

        // Fill, overflow, then full with a simultaneous pop
        for (int k = 1; k <= 6; k++) step(1'b1, 4'(k), 1'b0, 1'b0);
        check_val("ovf_drop", 32'(drop_m), 32'h2);
        check_val("ovf_full", 32'(full_m), 32'h1);
        step(1'b1, 4'h7, 1'b0, 1'b1);
        check_val("fp_count", 32'(count_m), 32'h3);
        check_val("fp_drop",  32'(drop_m), 32'h3);
        step(1'b1, 4'h7, 1'b0, 1'b0);
        check_val("fp_accept", 32'(count_m), 32'h4);
        for (int k = 0; k < 4; k++) step(1'b0, 4'h0, 1'b0, 1'b1);

        // Streaming through the wrap point
        sel1_before = int'(sel1_m);
        for (int k = 0; k < 3*DEPTH; k++) begin
            step(1'b1, 4'(k), k[0], 1'b1);
            check_val("st_count", 32'(count_m), 32'h1);
        end
        step(1'b0, 4'h0, 1'b0, 1'b1);
        check_val("st_sel1", 32'(int'(sel1_m) - sel1_before), 32'd6);

        // Saturation of the drop counter on the narrow instance
        for (int k = 0; k < DEPTH; k++) step(1'b1, 4'(k + 8), 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) step(1'b1, 4'hF, 1'b1, 1'b0);
        check_val("sat_drop_s", 32'(drop_s), 32'h7);

        // Asynchronous reset with two entries held
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        check_val("pre_rst_count", 32'(count_m), 32'h2);
        apply_reset_midcycle();

        // Random traffic
        for (int k = 0; k < 400; k++)
            step(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) != 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    task automatic step_idle_inputs();
        bus_m.in_valid = 1'b0; bus_m.in_data = '0; bus_m.in_sel = 1'b0; bus_m.out_ready = 1'b0;
        bus_s.in_valid = 1'b0; bus_s.in_data = '0; bus_s.in_sel = 1'b0; bus_s.out_ready = 1'b0;
    endtask
endmodule
